// File: rtl/usb_reg_fe.sv
// usb_reg_fe: USB microcontroller parallel bus (cwusb_*) to FPGA register
// file front-end.
//   cwusb_clk/reset      sole clock, asynchronous active-high reset
//   cwusb_din/dout       host write data in, registered read data out
//   cwusb_isout          data-bus output enable (READ/HOLD or I_drive_data)
//   cwusb_addr           host address, re-registered every cycle
//   cwusb_rdn/wrn/cen    active-low strobes and chip enable (synchronised)
//   reg_address/bytecnt  register address and byte index within a burst
//   reg_datao/reg_write  write data and its one-cycle strobe
//   reg_datai/reg_read   read data and the one-cycle read-start strobe
//   reg_addrvalid        synchronised chip enable
//   proto_err            sticky protocol error, only when the macro
//                        USB_REG_PROTO_ERR_EN is defined (else tied 0)
module usb_reg_fe #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSYNC_STAGES  = 2,
  parameter int pHOLD_CYCLES  = 2
) (
  input  logic                     cwusb_clk,
  input  logic                     reset,
  input  logic [7:0]               cwusb_din,
  output logic [7:0]               cwusb_dout,
  output logic                     cwusb_isout,
  input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
  input  logic                     cwusb_rdn,
  input  logic                     cwusb_wrn,
  input  logic                     cwusb_cen,
  input  logic                     I_drive_data,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     proto_err
);
  localparam int S = pSYNC_STAGES;
  // HOLD is entered with H-1 and left on the cycle it reads 0, so isout
  // stays up exactly pHOLD_CYCLES cycles after READ ends.
  localparam logic [3:0] HOLD_LD = (pHOLD_CYCLES > 0) ? 4'(pHOLD_CYCLES - 1) : 4'd0;
  localparam bit NO_HOLD = (pHOLD_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_e;

  // Synchroniser chain, bit order {cen, wrn, rdn}; prev_q is the edge-detect flop.
  logic [S-1:0][2:0] sync_q;
  logic [2:0]        prev_q;
  logic rd_s, wr_s, ce_s;
  logic rd_fall, rd_rise, wr_fall, wr_rise, ce_rise;

  always_ff @(posedge cwusb_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= {cwusb_cen, cwusb_wrn, cwusb_rdn};
      for (int i = 1; i < S; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[S-1];
    end
  end

  assign rd_s    = sync_q[S-1][0];
  assign wr_s    = sync_q[S-1][1];
  assign ce_s    = sync_q[S-1][2];
  assign rd_fall =  prev_q[0] & ~rd_s;
  assign rd_rise = ~prev_q[0] &  rd_s;
  assign wr_fall =  prev_q[1] & ~wr_s;
  assign wr_rise = ~prev_q[1] &  wr_s;
  assign ce_rise = ~prev_q[2] &  ce_s;

  state_e                   state_q;
  logic [3:0]               hold_q;
  logic                     read_q, write_q;
  logic [7:0]               dout_q, datao_q;
  logic [pADDR_WIDTH-1:0]   addr_q;
  logic [pBYTECNT_SIZE-1:0] cnt_q;
  logic                     rd_adv;

  // A read completes when READ/HOLD hands back to IDLE, or when a new read
  // starts out of HOLD. Aborts (ce rising) never advance.
  always_comb begin
    rd_adv = 1'b0;
    if (!ce_rise) begin
      case (state_q)
        READ:    rd_adv = NO_HOLD && rd_rise;
        HOLD:    rd_adv = rd_fall || (hold_q == 4'd0);
        default: rd_adv = 1'b0;
      endcase
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      dout_q  <= 8'd0;
      datao_q <= 8'd0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      if (state_q == READ) dout_q <= reg_datai;
      // Only capture din while the synchronised strobe is still low, so the
      // data presented with reg_write is the last value before wrn rose.
      if (state_q == WRITE && !wr_s) datao_q <= cwusb_din;
      if (ce_rise) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (wr_fall && !ce_s) state_q <= WRITE;
            else if (rd_fall && !ce_s) begin
              state_q <= READ;
              read_q  <= 1'b1;
            end
          end
          WRITE: begin
            if (wr_rise) begin
              write_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          READ: begin
            if (rd_rise) begin
              if (NO_HOLD) state_q <= IDLE;
              else begin
                state_q <= HOLD;
                hold_q  <= HOLD_LD;
              end
            end
          end
          HOLD: begin
            if (rd_fall) begin
              state_q <= READ;
              read_q  <= 1'b1;
            end else if (hold_q == 4'd0) state_q <= IDLE;
            else hold_q <= hold_q - 4'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Write completion is counted the cycle after the reg_write pulse so the
  // register file sees the pre-increment index alongside the strobe.
  always_ff @(posedge cwusb_clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= cwusb_addr;
      if (cwusb_addr != addr_q) cnt_q <= '0;
      else if (write_q || rd_adv) cnt_q <= cnt_q + pBYTECNT_SIZE'(1);
    end
  end

`ifdef USB_REG_PROTO_ERR_EN
  logic perr_q;
  always_ff @(posedge cwusb_clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else if ((~rd_s & ~wr_s & ~ce_s) || ((rd_fall | wr_fall) & ce_s)) perr_q <= 1'b1;
  end
  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

  assign cwusb_isout   = (state_q == READ) || (state_q == HOLD) || I_drive_data;
  assign cwusb_dout    = dout_q;
  assign reg_address   = addr_q;
  assign reg_bytecnt   = cnt_q;
  assign reg_datao     = datao_q;
  assign reg_read      = read_q;
  assign reg_write     = write_q;
  assign reg_addrvalid = ~ce_s;
endmodule

// File: tb/tb_usb_reg_fe.sv
module tb_usb_reg_fe;
  localparam int S = 2;
  localparam int H = 2;
`ifdef USB_REG_PROTO_ERR_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       cwusb_clk = 1'b0;
  logic       reset;
  logic [7:0] cwusb_din, cwusb_dout, cwusb_addr, reg_address, reg_datao, reg_datai;
  logic       cwusb_isout, cwusb_rdn, cwusb_wrn, cwusb_cen, I_drive_data;
  logic [6:0] reg_bytecnt;
  logic       reg_read, reg_write, reg_addrvalid, proto_err;

  usb_reg_fe #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7), .pSYNC_STAGES(S), .pHOLD_CYCLES(H)) dut (
    .cwusb_clk(cwusb_clk), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(cwusb_dout),
    .cwusb_isout(cwusb_isout), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
    .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .I_drive_data(I_drive_data),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
    .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid), .proto_err(proto_err));

  always #5 cwusb_clk = ~cwusb_clk;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [6:0] cnt;
  } exp_t;

  exp_t       acc_q[$];
  logic [7:0] dout_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  // Reference model: byte index restarts on a new address, +1 per completed access.
  logic [7:0] m_addr;
  int         m_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_acc(bit wr, logic [7:0] a, logic [7:0] d);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.cnt = 7'(m_cnt);
    acc_q.push_back(e);
  endtask

  // Monitor: every strobe is matched against the oldest expected access,
  // every end of a read (isout falling) against the expected read data.
  exp_t mon_e;
  bit   prev_iso = 1'b0, prev_drv = 1'b0;
  always @(negedge cwusb_clk) begin
    if (!reset) begin
      if (reg_write || reg_read) begin
        if (acc_q.size() == 0) chk("unexpected_strobe", {30'd0, reg_write, reg_read}, 32'd0);
        else begin
          mon_e = acc_q.pop_front();
          chk("strobe_kind", reg_write, mon_e.wr);
          chk("strobe_addr", reg_address, mon_e.addr);
          chk("strobe_bytecnt", reg_bytecnt, mon_e.cnt);
          if (mon_e.wr) chk("datao", reg_datao, mon_e.data);
        end
      end
      if (prev_iso && !cwusb_isout && !I_drive_data && !prev_drv) begin
        if (dout_q.size() == 0) chk("unexpected_rd_end", 1, 0);
        else chk("dout", cwusb_dout, dout_q.pop_front());
      end
    end
    prev_iso = cwusb_isout;
    prev_drv = I_drive_data;
  end

  task automatic clks(int n);
    repeat (n) @(negedge cwusb_clk);
  endtask

  task automatic set_addr(logic [7:0] a);
    if (a != m_addr) m_cnt = 0;
    m_addr = a;
    cwusb_addr = a;
    clks(2);
  endtask

  task automatic do_write(logic [7:0] a, logic [7:0] d, bit chg, logic [7:0] na);
    int c;
    set_addr(a);
    cwusb_din = d;
    push_acc(1'b1, a, d);
    cwusb_wrn = 1'b0;
    clks(S + 3);
    cwusb_wrn = 1'b1;
    for (c = 1; c <= 20; c++) begin
      @(negedge cwusb_clk);
      if (reg_write) break;
    end
    chk("wr_latency", c, S + 1);
    m_cnt = (m_cnt + 1) % 128;
    if (chg) begin
      cwusb_addr = na;
      m_addr = na;
      m_cnt = 0;
    end
    clks(1);
    chk("bytecnt_after_wr", reg_bytecnt, m_cnt);
    cwusb_din = 8'($urandom);
  endtask

  task automatic do_read(logic [7:0] a, logic [7:0] d, bit abort);
    int c;
    set_addr(a);
    reg_datai = d;
    push_acc(1'b0, a, 8'd0);
    dout_q.push_back(d);
    cwusb_rdn = 1'b0;
    for (c = 1; c <= 20; c++) begin
      @(negedge cwusb_clk);
      if (reg_read) break;
    end
    chk("rd_latency", c, S + 1);
    chk("isout_rd", cwusb_isout, 1);
    clks(3);
    if (abort) begin
      cwusb_cen = 1'b1;
      for (c = 1; c <= 20; c++) begin
        @(negedge cwusb_clk);
        if (!cwusb_isout) break;
      end
      chk("abort_latency", c, S + 1);
      cwusb_rdn = 1'b1;
      clks(3);
      chk("bytecnt_abort", reg_bytecnt, m_cnt);
      cwusb_cen = 1'b0;
      clks(3);
    end else begin
      cwusb_rdn = 1'b1;
      for (c = 1; c <= 30; c++) begin
        @(negedge cwusb_clk);
        if (!cwusb_isout) break;
      end
      chk("isout_fall", c, S + 1 + H);
      m_cnt = (m_cnt + 1) % 128;
      chk("bytecnt_after_rd", reg_bytecnt, m_cnt);
    end
    reg_datai = 8'($urandom);
  endtask

  initial begin
    int c, n;
    reset = 1'b1;
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; cwusb_cen = 1'b1;
    I_drive_data = 1'b0;
    cwusb_addr = 8'd0; cwusb_din = 8'd0; reg_datai = 8'd0;
    m_addr = 8'd0; m_cnt = 0;
    clks(3);
    chk("rst_outputs", {cwusb_dout, reg_address, reg_datao, 1'b0, reg_bytecnt}, 32'd0);
    chk("rst_strobes", {reg_read, reg_write, reg_addrvalid, proto_err, cwusb_isout}, 5'd0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge cwusb_clk);
      if (reg_read || reg_write || cwusb_isout) n++;
    end
    chk("idle_no_strobes", n, 0);
    chk("addrvalid_cen_hi", reg_addrvalid, 0);
    cwusb_cen = 1'b0;
    clks(S + 1);
    chk("addrvalid_cen_lo", reg_addrvalid, 1);
    I_drive_data = 1'b1;
    #1 chk("drive_data_isout", cwusb_isout, 1);
    clks(2);
    I_drive_data = 1'b0;
    #1 chk("drive_data_off", cwusb_isout, 0);
    clks(2);

    do_write(8'h12, 8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) do_read(8'h40, 8'(8'h10 + i), 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = ($urandom % 4 == 0) ? 8'($urandom) : m_addr;
      if ($urandom % 2) do_write(a, 8'($urandom), 1'b0, 8'h00);
      else do_read(a, 8'($urandom), 1'b0);
    end

    // 128 writes at one address: the last completion wraps the index to 0
    for (int i = 0; i < 128; i++) do_write(8'h33, 8'($urandom), 1'b0, 8'h00);
    chk("bytecnt_wrap", reg_bytecnt, 0);
    do_write(8'h33, 8'h5A, 1'b0, 8'h00);
    do_write(8'h33, 8'h6B, 1'b1, 8'h34);

    do_read(8'h34, 8'hC3, 1'b1);
    do_read(8'h34, 8'h3C, 1'b0);

    // reset while a write is in progress
    set_addr(8'h50);
    cwusb_wrn = 1'b0;
    clks(S + 3);
    reset = 1'b1;
    clks(2);
    chk("rst_mid_isout", {reg_write, cwusb_isout}, 0);
    cwusb_wrn = 1'b1;
    clks(2);
    reset = 1'b0;
    m_cnt = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge cwusb_clk);
      if (reg_write) n++;
    end
    chk("rst_mid_no_write", n, 0);
    chk("rst_mid_bytecnt", reg_bytecnt, 0);
    do_write(8'h50, 8'h77, 1'b0, 8'h00);
    chk("no_proto_err", proto_err, 0);

    // both strobes fall together: the write wins
    push_acc(1'b1, m_addr, 8'h99);
    cwusb_din = 8'h99;
    cwusb_rdn = 1'b0; cwusb_wrn = 1'b0;
    clks(S + 3);
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1;
    for (c = 1; c <= 20; c++) begin
      @(negedge cwusb_clk);
      if (reg_write) break;
    end
    chk("both_wr_latency", c, S + 1);
    m_cnt = (m_cnt + 1) % 128;
    chk("proto_err_set", proto_err, PE);
    clks(5);
    chk("proto_err_sticky", proto_err, PE);
    reset = 1'b1;
    clks(1);
    chk("proto_err_rst", proto_err, 0);
    reset = 1'b0;
    clks(5);

    chk("acc_q_empty", acc_q.size(), 0);
    chk("dout_q_empty", dout_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
